// File: rtl/sram_like_arbiter_pkg.sv
// Shared encodings for the sram-like request arbiter: access sizes, channel
// indices and the lock-state type.
package sram_like_arbiter_pkg;

  localparam logic [1:0] SRAM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] SRAM_SIZE_HALF = 2'd1;
  localparam logic [1:0] SRAM_SIZE_WORD = 2'd2;

  localparam int unsigned CH_INST = 0;
  localparam int unsigned CH_DATA = 1;

  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_t;

endpackage

// File: rtl/sram_like_arbiter_id_fifo.sv
// In-order FIFO of issuing-channel IDs for accepted, unanswered transactions.
module sram_like_arbiter_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ID_W  = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            push,
  input  logic            pop,
  input  logic [ID_W-1:0] din,
  output logic [ID_W-1:0] dout,
  output logic            full,
  output logic            empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ID_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Round-robin merge of N sram-like req/addr_ok/data_ok channels onto one
// memory port, with request locking and in-order response routing.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_wr,
  input  logic [2*NUM_CH-1:0]      ch_size,
  input  logic [ADDR_W*NUM_CH-1:0] ch_addr,
  input  logic [DATA_W*NUM_CH-1:0] ch_wdata,
  output logic [NUM_CH-1:0]        ch_addr_ok,
  output logic [NUM_CH-1:0]        ch_data_ok,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic                     mem_req,
  output logic                     mem_wr,
  output logic [1:0]               mem_size,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_addr_ok,
  input  logic                     mem_data_ok,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     proto_err
);

  localparam int unsigned ID_W = $clog2(NUM_CH);

  lock_state_t     lock_state, lock_state_nxt;
  logic [ID_W-1:0] lock_ch, lock_ch_nxt;
  logic [ID_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [ID_W-1:0] grant, g_hi, g_lo, fifo_dout;
  logic            found_hi;
  logic            fifo_full, fifo_empty;
  logic            accept, pop;

  // Cyclic search from rr_ptr: prefer requesters at/after the pointer, else wrap.
  always_comb begin
    g_hi     = '0;
    g_lo     = '0;
    found_hi = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_req[i]) begin
        g_lo = ID_W'(i);
        if (ID_W'(i) >= rr_ptr) begin
          g_hi     = ID_W'(i);
          found_hi = 1'b1;
        end
      end
    end
    if (lock_state == LOCK_HELD) grant = lock_ch;
    else if (found_hi)           grant = g_hi;
    else                         grant = g_lo;
  end

  assign mem_req    = (|ch_req) & ~fifo_full & resetn;
  assign mem_wr     = ch_wr[grant];
  assign mem_size   = ch_size[2*int'(grant) +: 2];
  assign mem_addr   = ch_addr[ADDR_W*int'(grant) +: ADDR_W];
  assign mem_wdata  = ch_wdata[DATA_W*int'(grant) +: DATA_W];

  assign accept     = mem_req & mem_addr_ok;
  assign ch_addr_ok = accept ? (NUM_CH'(1) << grant) : '0;

  assign pop        = mem_data_ok & ~fifo_empty;
  assign ch_data_ok = pop ? (NUM_CH'(1) << fifo_dout) : '0;
  assign ch_rdata   = mem_rdata;

  sram_like_arbiter_id_fifo #(
    .DEPTH (DEPTH),
    .ID_W  (ID_W)
  ) u_id_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (accept),
    .pop    (pop),
    .din    (grant),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock_state <= LOCK_IDLE;
      lock_ch    <= '0;
      rr_ptr     <= '0;
      proto_err  <= 1'b0;
    end else begin
      lock_state <= lock_state_nxt;
      lock_ch    <= lock_ch_nxt;
      rr_ptr     <= rr_ptr_nxt;
      proto_err  <= proto_err | (mem_data_ok & fifo_empty);
    end
  end

  // A presented but unaccepted request pins the grant until it is taken.
  always_comb begin
    lock_state_nxt = lock_state;
    lock_ch_nxt    = lock_ch;
    rr_ptr_nxt     = rr_ptr;
    if (accept) begin
      lock_state_nxt = LOCK_IDLE;
      rr_ptr_nxt     = (grant == ID_W'(NUM_CH - 1)) ? '0 : grant + ID_W'(1);
    end else if (mem_req) begin
      lock_state_nxt = LOCK_HELD;
      lock_ch_nxt    = grant;
    end
  end

endmodule

// File: doc/sram_like_arbiter.md
# sram_like_arbiter

- Parametrised N-channel arbiter that merges the CPU's instruction-fetch and data-access request channels onto one shared sram-like memory port. Each channel uses the req / addr_ok / data_ok split-transaction handshake.
- Sits between the pipeline stages and the external memory/bridge. It replaces the dedicated fixed-latency inst/data SRAM ports.
- Arbitrates round-robin and holds a request stable until it is accepted. It tracks up to DEPTH outstanding transactions in order and routes each response back to the channel that issued it.

## Interface
- NUM_CH, 2: number of requesting channels (≥2); channel 0 = inst, channel 1 = data.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- DEPTH, 4: max outstanding accepted-but-unanswered transactions (power of 2, ≥2).
- clk  in  1  single clock, all state on rising edge.
- resetn  in  1  synchronous, active-low reset.
- ch_req  in  NUM_CH  per-channel request.
- ch_wr  in  NUM_CH  per-channel write (1) / read (0).
- ch_size  in  2*NUM_CH  per-channel size (0=byte, 1=half, 2=word), channel i at [2i+1:2i].
- ch_addr  in  ADDR_W*NUM_CH  per-channel address, packed the same way.
- ch_wdata  in  DATA_W*NUM_CH  per-channel write data.
- ch_addr_ok  out  NUM_CH  request accepted this cycle.
- ch_data_ok  out  NUM_CH  response returned this cycle.
- ch_rdata  out  DATA_W  read data, broadcast to all channels; valid with ch_data_ok.
- mem_req / mem_wr  out  1 / 1  downstream request and direction.
- mem_size  out  2  downstream size.
- mem_addr  out  ADDR_W  downstream address.
- mem_wdata  out  DATA_W  downstream write data.
- mem_addr_ok / mem_data_ok  in  1 / 1  downstream accept and response.
- mem_rdata  in  DATA_W  downstream read data.
- proto_err  out  1  sticky flag: a mem_data_ok arrived with nothing outstanding.

## Operation
- Grant selection:
  - If lock_vld, the grant is lock_ch.
  - Otherwise the grant is the first requesting channel at or after rr_ptr, searching cyclically.
- mem_req = (any ch_req) & ~fifo_full & resetn. mem_wr, mem_size, mem_addr and mem_wdata are muxed from the granted channel.
- Acceptance:
  - ch_addr_ok[g] = mem_req & mem_addr_ok & grant[g].
  - On acceptance, push g into the ID FIFO and set rr_ptr = (g+1) mod NUM_CH.
- Lock:
  - If mem_req & ~mem_addr_ok, set lock_vld=1 and lock_ch=g, so the request stays stable until accepted.
  - Clear lock_vld on acceptance.
  - A locked channel must keep ch_req high. Dropping it is a channel protocol violation, and the lock is not released.
- Response:
  - On mem_data_ok with the FIFO non-empty, ch_data_ok[head]=1, ch_rdata=mem_rdata, and the FIFO pops.
  - With the FIFO empty, mem_data_ok is ignored and proto_err is set.
- Responses are in order. The downstream port must return data_ok in acceptance order.
- Push and pop in the same cycle are both performed and the count is unchanged.
- When full, no push is possible even if a pop occurs that cycle. There is no data_ok→req combinational path.
- Reset (resetn=0 at a clock edge):
  - rr_ptr=0, lock_vld=0, FIFO empty, proto_err=0.
  - Any in-flight transactions are forgotten. The downstream port must be reset together with this block.
- Output values: mem_req=0 while resetn=0. ch_addr_ok and ch_data_ok are 0 whenever mem_req or mem_data_ok respectively are 0.

## Timing
- Request path is combinational: ch_req→mem_req and mem_addr_ok→ch_addr_ok in the same cycle.
- Response path is combinational: mem_data_ok/mem_rdata→ch_data_ok/ch_rdata in the same cycle. The block adds zero cycles of latency.
- Throughput: one acceptance and one response per cycle.
- Pointer wrap: the FIFO read/write pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits. Full = count==DEPTH, empty = count==0.
- rr_ptr wraps from NUM_CH-1 to 0.
- A lock taken in cycle t forces the grant from cycle t+1 onward, regardless of higher-priority requests.

## Structure
- Shared define header: SRAM_SIZE_BYTE/HALF/WORD encodings and the CH_INST=0 / CH_DATA=1 indices.
- Sub-module id_fifo:
  - Parameters DEPTH and ID_W=clog2(NUM_CH).
  - Ports: push, pop, din, dout, full, empty.
  - Synchronous active-low reset; write-before-read is not required.
- Top of the CPU instantiates sram_like_arbiter with NUM_CH=2 and feeds the inst/data sram-like ports of the IF and EXE/MEM stages.

## Test plan
- Single read:
  - Stimulus: ch0 req, addr 0xBFC00000. mem_addr_ok=1 the same cycle. mem_data_ok 3 cycles later with rdata 0x3C1D0000.
  - Required: ch_addr_ok=01 in cycle 0; ch_data_ok=01 in cycle 3 with ch_rdata=0x3C1D0000.
- Round-robin:
  - Stimulus: both channels request continuously, mem_addr_ok=1 every cycle.
  - Required: grants alternate 0,1,0,1.
- Lock:
  - Stimulus: ch1 requests with mem_addr_ok=0 for 3 cycles while ch0 raises req in cycle 1.
  - Required: mem_addr stays at ch1's address; on cycle 3 accept, ch_addr_ok=10, and ch0 is granted next.
- Full and ordering:
  - Stimulus: DEPTH=4; issue reads ch0,ch1,ch0,ch1 with no data_ok.
  - Required: mem_req=0 while the FIFO is full.
  - Then issue 4 data_ok with rdata 1..4. Required: ch_data_ok returns 01,10,01,10 with matching data.
  - Pop+push test: a pop on the full cycle still blocks mem_req that cycle; the next cycle's push is accepted.
- Error and reset:
  - Stimulus: mem_data_ok with the FIFO empty. Required: proto_err=1 and no ch_data_ok.
  - Stimulus: resetn=0 mid-burst with 2 outstanding. Required: after reset, the FIFO is empty, proto_err=0 and mem_req=0 during reset.
